// File: rtl/m_imem_loader.sv
// Instruction memory loader: streams a program into a small word RAM, then lets the core fetch it.
// Optional macro IMEM_OPCODE_CHECK_EN: replace non R-type words with NOP and flag w_err.
module m_imem_loader #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_start,
    input  logic [5:0]  w_len,
    input  logic        w_in_valid,
    input  logic [31:0] w_in_data,
    output logic        w_in_ready,
    input  logic [31:0] w_pc,
    output logic [31:0] w_ir,
    output logic        w_run,
    output logic [5:0]  w_cnt,
    output logic        w_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [5:0]  DepthCnt = 6'(DEPTH);
    localparam logic [31:0] Nop      = 32'h0000_0033;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    tgt_q, tgt_d;
    logic          err_q, err_d;
    logic [5:0]    len_clip;
    logic [5:0]    cnt_inc;
    logic          xfer;
    logic          bad_op;
    logic [31:0]   wr_data;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_idx;
    logic          addr_ok;

    assign len_clip = (w_len > DepthCnt) ? DepthCnt : w_len;
    assign xfer     = (state_q == StLoad) && w_in_valid;
    assign cnt_inc  = (cnt_q == DepthCnt) ? cnt_q : cnt_q + 6'd1;

`ifdef IMEM_OPCODE_CHECK_EN
    assign bad_op  = (w_in_data[6:0] != 7'b0110011);
    assign wr_data = bad_op ? Nop : w_in_data;
`else
    assign bad_op  = 1'b0;
    assign wr_data = w_in_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StRun: begin
                if (w_start) begin
                    tgt_d   = len_clip;
                    cnt_d   = 6'd0;
                    err_d   = 1'b0;
                    // An empty program has nothing to load, so it is runnable at once.
                    state_d = (len_clip == 6'd0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                if (w_in_valid) begin
                    cnt_d = cnt_inc;
                    if (bad_op) err_d = 1'b1;
                    if (cnt_inc == tgt_q) state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            tgt_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; the fetch guard on cnt_q hides stale contents.
    always_ff @(posedge w_clk) begin
        if (xfer && (cnt_q < DepthCnt)) begin
            mem_q[cnt_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_idx  = w_pc[AW+1:2];
    assign addr_ok = (w_pc[1:0] == 2'b00) && (w_pc[31:AW+2] == '0) && (6'(rd_idx) < cnt_q);

    assign w_ir       = addr_ok ? mem_q[rd_idx] : Nop;
    assign w_in_ready = (state_q == StLoad);
    assign w_run      = (state_q == StRun);
    assign w_cnt      = cnt_q;
    assign w_err      = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader: directed vector tables, corner sequences and
// randomized loads checked against a word-level reference model.
module tb_m_imem_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h0000_0033;

    logic        w_clk;
    logic        w_rst;
    logic        w_start;
    logic [5:0]  w_len;
    logic        w_in_valid;
    logic [31:0] w_in_data;
    logic        w_in_ready;
    logic [31:0] w_pc;
    logic [31:0] w_ir;
    logic        w_run;
    logic [5:0]  w_cnt;
    logic        w_err;

    m_imem_loader #(.DEPTH(DEPTH)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_start    (w_start),
        .w_len      (w_len),
        .w_in_valid (w_in_valid),
        .w_in_data  (w_in_data),
        .w_in_ready (w_in_ready),
        .w_pc       (w_pc),
        .w_ir       (w_ir),
        .w_run      (w_run),
        .w_cnt      (w_cnt),
        .w_err      (w_err)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = loading, 2 = running.
    int          m_state;
    int          m_cnt;
    int          m_tgt;
    logic        m_err;
    logic [31:0] m_mem [DEPTH];

    typedef struct {
        logic        st;
        logic [5:0]  len;
        logic        v;
        logic [31:0] d;
        logic        exp_ready;
        logic [5:0]  exp_cnt;
        logic        exp_run;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } fvec_t;

    vec_t  vecs [5];
    fvec_t fvecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_ir(input logic [31:0] pc);
        if ((pc[1:0] == 2'b00) && (pc < 32'(4 * m_cnt))) return m_mem[int'(pc >> 2)];
        return NOP;
    endfunction

    task automatic model_step(input logic st, input logic [5:0] len, input logic v,
                              input logic [31:0] d);
        logic bad;
`ifdef IMEM_OPCODE_CHECK_EN
        bad = (d[6:0] != 7'b0110011);
`else
        bad = 1'b0;
`endif
        if (m_state != 1 && st) begin
            m_tgt   = (int'(len) > DEPTH) ? DEPTH : int'(len);
            m_cnt   = 0;
            m_err   = 1'b0;
            m_state = (m_tgt == 0) ? 2 : 1;
        end else if (m_state == 1 && v) begin
            m_mem[m_cnt] = bad ? NOP : d;
            if (bad) m_err = 1'b1;
            m_cnt++;
            if (m_cnt == m_tgt) m_state = 2;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cnt"}, 32'(w_cnt), 32'(m_cnt));
        chk({tag, "_run"}, 32'(w_run), 32'(m_state == 2));
        chk({tag, "_ready"}, 32'(w_in_ready), 32'(m_state == 1));
        chk({tag, "_err"}, 32'(w_err), 32'(m_err));
    endtask

    task automatic cycle(input logic st, input logic [5:0] len, input logic v,
                         input logic [31:0] d);
        @(negedge w_clk);
        w_start    = st;
        w_len      = len;
        w_in_valid = v;
        w_in_data  = d;
        model_step(st, len, v, d);
        @(posedge w_clk);
        #1;
        check_state("cyc");
        w_start    = 1'b0;
        w_in_valid = 1'b0;
    endtask

    task automatic fetch_chk(input logic [31:0] pc);
        @(negedge w_clk);
        w_pc = pc;
        #1;
        chk("ir_model", w_ir, model_ir(pc));
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst = 1'b1;
        #1;
        m_state = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        check_state("rst");
        @(posedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] r;
        logic [31:0] r2;
        logic [31:0] d;
        logic [31:0] pc;

        w_rst = 1'b1; w_start = 1'b0; w_len = '0; w_in_valid = 1'b0;
        w_in_data = '0; w_pc = '0;
        m_state = 0; m_cnt = 0; m_tgt = 0; m_err = 1'b0;

        vecs[0] = '{1'b1, 6'd3, 1'b0, 32'h0,         1'b1, 6'd0, 1'b0};
        vecs[1] = '{1'b0, 6'd0, 1'b1, 32'h001000b3,  1'b1, 6'd1, 1'b0};
        vecs[2] = '{1'b0, 6'd0, 1'b1, 32'h000080b3,  1'b1, 6'd2, 1'b0};
        vecs[3] = '{1'b0, 6'd0, 1'b1, 32'h001080b3,  1'b0, 6'd3, 1'b1};
        vecs[4] = '{1'b0, 6'd0, 1'b1, 32'hdead00b3,  1'b0, 6'd3, 1'b1};

        fvecs[0] = '{32'h0,         32'h001000b3};
        fvecs[1] = '{32'h4,         32'h000080b3};
        fvecs[2] = '{32'h8,         32'h001080b3};
        fvecs[3] = '{32'hC,         NOP};
        fvecs[4] = '{32'h2,         NOP};
        fvecs[5] = '{32'h80,        NOP};
        fvecs[6] = '{32'h1000_0000, NOP};

        // Reset state
        do_reset();
        fetch_chk(32'h0);
        chk("reset_ir", w_ir, NOP);
        chk("reset_run", 32'(w_run), 32'h0);
        chk("reset_ready", 32'(w_in_ready), 32'h0);
        chk("reset_cnt", 32'(w_cnt), 32'h0);

        // Three-word load, valid held high
        for (int i = 0; i < 5; i++) begin
            cycle(vecs[i].st, vecs[i].len, vecs[i].v, vecs[i].d);
            chk("vec_ready", 32'(w_in_ready), 32'(vecs[i].exp_ready));
            chk("vec_cnt", 32'(w_cnt), 32'(vecs[i].exp_cnt));
            chk("vec_run", 32'(w_run), 32'(vecs[i].exp_run));
        end
        for (int i = 0; i < 7; i++) begin
            fetch_chk(fvecs[i].pc);
            chk("fetch_tbl", w_ir, fvecs[i].ir);
        end

        // Toggled valid with an ignored start pulse mid-load
        cycle(1'b1, 6'd4, 1'b0, 32'h0);
        chk("tog_start_cnt", 32'(w_cnt), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(i == 3, 6'd1, (i % 2) == 0, 32'h00a0_0033 + 32'(i << 12));
            chk("tog_cnt", 32'(w_cnt), 32'(i / 2 + 1 > 4 ? 4 : i / 2 + 1));
            chk("tog_run", 32'(w_run), 32'(i >= 6));
        end
        fetch_chk(32'h4);

        // Zero-length load
        cycle(1'b1, 6'd0, 1'b0, 32'h0);
        chk("len0_run", 32'(w_run), 32'h1);
        chk("len0_cnt", 32'(w_cnt), 32'h0);
        fetch_chk(32'h0);
        chk("len0_ir", w_ir, NOP);

        // Oversized length clips to DEPTH
        cycle(1'b1, 6'd40, 1'b0, 32'h0);
        n = 0;
        while (w_in_ready && n < 50) begin
            cycle(1'b0, 6'd0, 1'b1, {25'(n + 1), 7'h33});
            n++;
        end
        chk("len40_xfers", 32'(n), 32'd32);
        chk("len40_cnt", 32'(w_cnt), 32'd32);
        chk("len40_run", 32'(w_run), 32'h1);
        cycle(1'b0, 6'd0, 1'b1, 32'h0bad_0033);
        chk("len40_hold", 32'(w_cnt), 32'd32);
        fetch_chk(32'h7C);
        chk("len40_last", w_ir, {25'd32, 7'h33});
        fetch_chk(32'h80);
        chk("len40_pc80", w_ir, NOP);
        fetch_chk(32'h2);
        chk("len40_pc2", w_ir, NOP);

        // Reset mid-load
        cycle(1'b1, 6'd5, 1'b0, 32'h0);
        cycle(1'b0, 6'd0, 1'b1, 32'h0011_0033);
        cycle(1'b0, 6'd0, 1'b1, 32'h0022_0033);
        do_reset();
        chk("midrst_cnt", 32'(w_cnt), 32'h0);
        fetch_chk(32'h0);
        chk("midrst_ir", w_ir, NOP);

        // Reload from RUN with length 1
        for (int i = 0; i < 4; i++) cycle(vecs[i].st, vecs[i].len, vecs[i].v, vecs[i].d);
        cycle(1'b1, 6'd1, 1'b0, 32'h0);
        chk("reload_run", 32'(w_run), 32'h0);
        chk("reload_ready", 32'(w_in_ready), 32'h1);
        cycle(1'b0, 6'd0, 1'b1, 32'h0055_00b3);
        chk("reload_done", 32'(w_run), 32'h1);
        fetch_chk(32'h4);
        chk("reload_pc4", w_ir, NOP);
        fetch_chk(32'h0);
        chk("reload_pc0", w_ir, 32'h0055_00b3);

        // Opcode check
        cycle(1'b1, 6'd1, 1'b0, 32'h0);
        cycle(1'b0, 6'd0, 1'b1, 32'h0000_0013);
        fetch_chk(32'h0);
`ifdef IMEM_OPCODE_CHECK_EN
        chk("op_err", 32'(w_err), 32'h1);
        chk("op_ir", w_ir, NOP);
`else
        chk("op_err", 32'(w_err), 32'h0);
        chk("op_ir", w_ir, 32'h0000_0013);
`endif
        cycle(1'b1, 6'd2, 1'b0, 32'h0);
        chk("op_err_clr", 32'(w_err), 32'h0);

        // Randomized loads and reloads
        for (int rnd = 0; rnd < 20; rnd++) begin
            cycle(1'b1, 6'($urandom_range(0, 40)), 1'b0, 32'h0);
            for (int c = 0; c < 200 && m_state == 1; c++) begin
                r  = $urandom;
                r2 = $urandom;
                d  = (r2 % 4 == 0) ? r : {r[31:7], 7'h33};
                cycle(($urandom % 8) == 0, 6'($urandom_range(0, 40)), r2[4], d);
                case ($urandom % 4)
                    0:       pc = 32'($urandom_range(0, 31) * 4);
                    1:       pc = 32'($urandom_range(0, 160));
                    2:       pc = $urandom;
                    default: pc = 32'(m_cnt * 4) - 32'(($urandom % 2) * 4);
                endcase
                fetch_chk(pc);
            end
            for (int k = 0; k < 3; k++) fetch_chk(32'($urandom_range(0, 33) * 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_imem_loader.md
M_IMEM_LOADER -- requirements
Module: m_imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit instruction words stored (power of two, 2..32).
REQ-002 SHALL have port w_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port w_rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port w_start, input, 1, level sampled each cycle; starts a program load.
REQ-005 SHALL have port w_len, input, 6, number of words to load; sampled only on the accepting w_start cycle.
REQ-006 SHALL have port w_in_valid, input, 1, the producer offers w_in_data.
REQ-007 SHALL have port w_in_data, input, 32, the instruction word.
REQ-008 SHALL have port w_in_ready, output, 1, the loader accepts a word this cycle.
REQ-009 SHALL have port w_pc, input, 32, the fetch byte address from the processor.
REQ-010 SHALL have port w_ir, output, 32, the fetched instruction (combinational read).
REQ-011 SHALL have port w_run, output, 1, the program is loaded and the processor may fetch.
REQ-012 SHALL have port w_cnt, output, 6, the number of words written in the current load.
REQ-013 SHALL have port w_err, output, 1, sticky opcode-check error (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and RUN; w_in_ready=1 only in LOAD, and w_run=1 only in RUN.
REQ-015 IDLE or RUN with w_start=1 SHALL go to LOAD next cycle, clear w_cnt and w_err, and latch target = min(w_len, DEPTH).
REQ-016 If the latched target is 0, SHALL go directly to RUN instead of LOAD, with w_cnt=0.
REQ-017 In LOAD, a transfer is valid&ready; SHALL write w_in_data to mem[w_cnt] and increment w_cnt by 1.
REQ-018 A transfer making w_cnt equal the target SHALL move to RUN next cycle; w_in_ready=0 from that cycle on, and no extra word is accepted.
REQ-019 w_start in LOAD SHALL be ignored; valid=0 in LOAD SHALL hold all state.
REQ-020 Fetch: idx=w_pc[log2(DEPTH)+1:2]; w_ir SHALL be mem[idx] when w_pc[1:0]==0, all upper w_pc bits are 0, and idx<w_cnt; otherwise w_ir SHALL be the NOP 32'h00000033 (add x0,x0,x0).
REQ-021 w_ir SHALL be valid in every state, so words already written are fetchable during LOAD.
REQ-022 A word written on edge N SHALL be visible on w_ir after edge N (zero-latency read, one-cycle write).
REQ-023 w_cnt SHALL saturate at DEPTH and never wrap.

Reset
REQ-024 Asserting w_rst SHALL immediately force IDLE, w_cnt=0, w_in_ready=0, w_run=0 and w_err=0, including mid-load.
REQ-025 Memory array SHALL NOT be reset; because w_cnt=0, w_ir reads NOP after reset regardless of array contents.

Configuration
REQ-026 With macro IMEM_OPCODE_CHECK_EN defined, a transferred word whose bits [6:0] != 7'b0110011 SHALL set w_err (sticky until reset or the next accepted start) and SHALL be stored as 32'h00000033; w_cnt still increments.
REQ-027 Without IMEM_OPCODE_CHECK_EN, w_err SHALL be constant 0 and words SHALL be stored verbatim.

Verification
REQ-028 Reset, then w_pc=0 -> w_ir=32'h00000033, w_run=0, w_in_ready=0, w_cnt=0.
REQ-029 Start with w_len=3, valid held high with words 32'h001000b3, 32'h000080b3, 32'h001080b3 -> three transfers on consecutive cycles; w_ready falls the cycle after the third; w_run=1; w_pc=0/4/8 return those words; w_pc=12 returns NOP.
REQ-030 Start with w_len=4, valid toggled 1,0,1,0,... -> w_cnt increments only on valid cycles; w_start pulsed mid-load is ignored; w_run rises after the 4th transfer.
REQ-031 w_len=0 -> RUN next cycle, w_cnt=0; w_len=40 with DEPTH=32 -> exactly 32 transfers, then RUN; w_pc=2 or 32'h80 -> NOP.
REQ-032 Assert w_rst after 2 of 5 words -> w_cnt=0 immediately, IDLE; w_pc=0 reads NOP. A reload from RUN with w_len=1 -> w_run=0 during LOAD and w_pc=4 returns NOP afterwards.
REQ-033 With IMEM_OPCODE_CHECK_EN defined, load 32'h00000013 -> w_err=1, w_pc=0 returns 32'h00000033; the next start clears w_err. Without the macro, w_err stays 0 and the word reads back as 32'h00000013.
